// File: rtl/demux_scan_ctrl.sv
// Clocked scan engine for the 1:16 demux stage: steps s through a captured
// channel range, holding each channel DWELL cycles with din held constant.
module demux_scan_ctrl #(
  parameter int SEL_W = 4,
  parameter int DWELL = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic [SEL_W-1:0] first_ch,
  input  logic [SEL_W-1:0] last_ch,
  output logic             din,
  output logic [SEL_W-1:0] s,
  output logic             ch_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             bit_q, bit_d;
  logic [SEL_W-1:0] s_d;
  logic             din_d, chv_d, busy_d, done_d;

  // Every output is a flop; next values are computed here per transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    bit_d   = bit_q;
    s_d     = '0;
    din_d   = 1'b0;
    chv_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d = DRIVE;
          bit_d   = bit_in;
          last_d  = last_ch;
          s_d     = first_ch;
          din_d   = bit_in;
          chv_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (s == last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            // Wraps modulo 2**SEL_W; din stays put across the channel change.
            s_d    = s + SEL_W'(1);
            din_d  = bit_q;
            chv_d  = 1'b1;
            busy_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          s_d    = s;
          din_d  = bit_q;
          chv_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      bit_q    <= 1'b0;
      s        <= '0;
      din      <= 1'b0;
      ch_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      bit_q    <= bit_d;
      s        <= s_d;
      din      <= din_d;
      ch_valid <= chv_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench: each scan pushes its per-cycle expected outputs, which are
// popped and compared against the DUT on every falling edge.
module tb_demux_scan_ctrl;
  localparam int D0 = 10;
  localparam int D1 = 1;

  logic       clk = 1'b0;
  logic       rst, start0, start1, abort, bit_in;
  logic [3:0] first_ch, last_ch;
  logic       din0, chv0, busy0, done0;
  logic       din1, chv1, busy1, done1;
  logic [3:0] s0, s1;

  int tests = 0;
  int fails = 0;
  int lat;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  demux_scan_ctrl #(.SEL_W(4), .DWELL(D0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .bit_in(bit_in),
    .first_ch(first_ch), .last_ch(last_ch), .din(din0), .s(s0),
    .ch_valid(chv0), .busy(busy0), .done(done0));

  demux_scan_ctrl #(.SEL_W(4), .DWELL(D1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .bit_in(bit_in),
    .first_ch(first_ch), .last_ch(last_ch), .din(din1), .s(s1),
    .ch_valid(chv1), .busy(busy1), .done(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pk(logic d, logic [3:0] sel, logic c, logic b, logic dn);
    return {d, sel, c, b, dn};
  endfunction

  task automatic push(input int which, input logic [7:0] v);
    if (which != 0) q1.push_back(v);
    else q0.push_back(v);
  endtask

  // Model: N channels from f wrapping mod 16, each held for the DUT's dwell,
  // then one DONE cycle, then the first IDLE cycle.
  task automatic start_scan(input int which, input logic b, input logic [3:0] f, input logic [3:0] l);
    int d;
    int n;
    logic [3:0] ch;
    d  = (which != 0) ? D1 : D0;
    n  = ((int'(l) - int'(f) + 16) % 16) + 1;
    ch = f;
    bit_in   = b;
    first_ch = f;
    last_ch  = l;
    if (which != 0) start1 = 1'b1;
    else start0 = 1'b1;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < d; c++) push(which, pk(b, ch, 1'b1, 1'b1, 1'b0));
      ch = ch + 4'd1;
    end
    push(which, pk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1));
    push(which, pk(1'b0, 4'd0, 1'b0, 0, 1'b0));
  endtask

  // Pops both scoreboards each cycle; returns the cycle index of the first done.
  task automatic drain(input int abort_at, input int poke_at, output int done_at);
    int i;
    i = 0;
    done_at = 0;
    while (q0.size() > 0 || q1.size() > 0) begin
      @(negedge clk);
      i++;
      if (q0.size() > 0) chk($sformatf("u0_cyc%0d", i), {24'd0, din0, s0, chv0, busy0, done0}, {24'd0, q0.pop_front()});
      if (q1.size() > 0) chk($sformatf("u1_cyc%0d", i), {24'd0, din1, s1, chv1, busy1, done1}, {24'd0, q1.pop_front()});
      if (done_at == 0 && (done0 === 1'b1 || done1 === 1'b1)) done_at = i;
      start0 = 1'b0;
      start1 = 1'b0;
      abort  = (i == abort_at);
      if (i == poke_at) begin
        start0   = 1'b1;
        first_ch = first_ch + 4'd3;
        last_ch  = last_ch + 4'd5;
        bit_in   = ~bit_in;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1; bit_in = 1'b1; abort = 1'b0;
    first_ch = 4'd0; last_ch = 4'd0;

    // Reset dominates a pending start.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_u0", {24'd0, din0, s0, chv0, busy0, done0}, 32'd0);
      chk("rst_u1", {24'd0, din1, s1, chv1, busy1, done1}, 32'd0);
    end
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_u0", {24'd0, din0, s0, chv0, busy0, done0}, 32'd0);
    end

    // Full 16-channel scan; mid-scan start/range/bit changes must be ignored.
    start_scan(0, 1'b1, 4'd0, 4'd15);
    drain(0, 50, lat);
    chk("full_done_lat", lat, 32'd161);

    // Back-to-back wrapping scan started in the first IDLE cycle after done.
    start_scan(0, 1'b0, 4'd14, 4'd1);
    drain(0, 0, lat);
    chk("wrap_done_lat", lat, 32'd41);

    // DWELL=1 single channel.
    start_scan(1, 1'b1, 4'd5, 4'd5);
    drain(0, 0, lat);
    chk("single_done_lat", lat, 32'd2);

    // DWELL=1 wrapping scan: s moves every cycle.
    start_scan(1, 1'b0, 4'd15, 4'd2);
    drain(0, 0, lat);
    chk("d1_wrap_done_lat", lat, 32'd5);

    // Abort sampled while s=3: idle outputs next cycle, no done afterwards.
    start_scan(0, 1'b1, 4'd0, 4'd15);
    while (q0.size() > 33) q0.delete(q0.size() - 1);
    for (int i = 0; i < 20; i++) q0.push_back(8'd0);
    drain(33, 0, lat);
    chk("abort_no_done", lat, 32'd0);

    // Start together with abort in IDLE stays idle.
    @(negedge clk);
    start0 = 1'b1; abort = 1'b1; bit_in = 1'b1; first_ch = 4'd7;
    @(negedge clk);
    chk("start_abort_idle", {24'd0, din0, s0, chv0, busy0, done0}, 32'd0);
    start0 = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle2", {24'd0, din0, s0, chv0, busy0, done0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux_scan_ctrl.md
Name: demux_scan_ctrl

Overview:
- Sequential controller that drives the `din`/`s` inputs of the 1:16 demultiplexer stage (`demux1_16`).
- On a start request it steps the select through a programmed channel range, holding each channel for a fixed dwell time, then signals completion.
- Replaces hand-written select stepping with a reusable, clocked scan engine. It sits directly upstream of the demux.

Parameters:
- SEL_W, 4, select width; channel count is 2**SEL_W (16).
- DWELL, 10, clock cycles each channel is held; legal range 1..255.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle scan request; sampled only in IDLE.
- abort, input, 1, terminates an active scan.
- bit_in, input, 1, data value driven on din for the whole scan; captured at start.
- first_ch, input, SEL_W, first channel of the scan; captured at start.
- last_ch, input, SEL_W, last channel of the scan; captured at start.
- din, output, 1, data to demux.
- s, output, SEL_W, select to demux.
- ch_valid, output, 1, high while din/s are being driven for a channel.
- busy, output, 1, high from the cycle after start until return to IDLE.
- done, output, 1, one-cycle pulse at normal scan completion.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over all other inputs.
  - State returns to IDLE.
  - din=0, s=0, ch_valid=0, busy=0, done=0.
  - Dwell counter and captured registers are cleared.
  - Reset mid-scan aborts the scan without a done pulse.
- All outputs are registered and there are no combinational paths from inputs to outputs.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - Outputs are din=0, s=0, ch_valid=0, busy=0.
  - On start=1 the block captures bit_in, first_ch and last_ch.
  - Next cycle it enters DRIVE with s=first_ch, din=bit_in (captured), ch_valid=1, busy=1, and the dwell counter at 0.
  - start=1 together with abort=1 in IDLE: abort wins and the state stays IDLE.
- DRIVE:
  - The dwell counter increments each cycle; each channel is held exactly DWELL cycles.
  - In the last dwell cycle (counter = DWELL-1), if s == last_ch captured, the next state is DONE.
  - Otherwise s increments modulo 2**SEL_W (15 wraps to 0) and the counter resets to 0.
  - din holds its captured value continuously across channel changes, with no bubble cycle.
  - first_ch == last_ch gives a single channel held DWELL cycles.
  - last_ch < first_ch gives a wrapping scan (e.g. 14,15,0,1).
  - Captured values cause a full 16-channel scan when last_ch = first_ch-1 mod 16.
  - Changes on first_ch, last_ch or bit_in during a scan are ignored.
  - start during DRIVE is ignored.
- Abort: abort=1 in DRIVE leads next cycle to IDLE outputs (din=0, s=0, ch_valid=0, busy=0), with no done pulse.
- DONE (one cycle):
  - Outputs are done=1, ch_valid=0, din=0, s=0, busy=1.
  - Next state is IDLE unconditionally; abort and start are ignored in DONE.
  - A start in the first IDLE cycle after DONE is accepted.
- Scan timing:
  - Total scan length from the start edge to the done pulse is 1 + N*DWELL cycles, where N = ((last_ch - first_ch) mod 16) + 1.
  - The done pulse itself occupies the cycle immediately after the final dwell cycle.
- DWELL=1: s changes every cycle.
- Counter width is ceil(log2(DWELL+1)) bits.

Test Plan:
- Reset check: rst=1 for 2 cycles with start=1 and bit_in=1 -> all outputs 0 and state IDLE. After rst=0 with no start, outputs stay 0.
- Full scan: DWELL=10, bit_in=1, first_ch=0, last_ch=15, start pulse ->
  - s steps 0000..1111, each held 10 cycles, with din=1 and ch_valid=1 throughout.
  - done pulses exactly 161 cycles after the start edge; busy drops the next cycle.
- Wrapping partial scan: first_ch=14, last_ch=1, bit_in=0 ->
  - s sequence 14,15,0,1, each 10 cycles, with din=0 and ch_valid=1.
  - done after 41 cycles.
- Single channel with DWELL=1: first_ch=last_ch=5 -> s=5 for 1 cycle, then done=1 next cycle, then IDLE.
- Abort mid-scan: full scan started, abort=1 while s=3 -> next cycle din=0, s=0, ch_valid=0, busy=0, and done never asserts.
- Ignored inputs:
  - start pulsed while busy has no effect.
  - first_ch changed mid-scan has no effect on the current range.
  - Back-to-back: start asserted on the cycle after done -> a new scan begins with s=first_ch on the following cycle.
